// File: rtl/clk_div_sel_seq.sv
// clk_div_sel_seq: refclk-domain sequencer that flips divclk_sel behind a hold req/ack handshake.
// Define CLK_DIV_SEL_TIMEOUT_EN to abort with err when hold_ack does not arrive within TIMEOUT_CYC.
module clk_div_sel_seq #(
    parameter int DIV         = 8,
    parameter int SETTLE_CYC  = 4 * DIV,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic refclk,
    input  logic rst,
    input  logic dft_en,
    input  logic cmd_valid,
    input  logic cmd_sel,
    output logic cmd_ready,
    output logic hold_req,
    input  logic hold_ack,
    output logic divclk_sel,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int MAXC = SETTLE_CYC > TIMEOUT_CYC ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, QUIESCE, SWITCH, RELEASE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic tgt_q, tgt_d, sel_q, sel_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
    logic accept;
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            sel_q   <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (cmd_sel == sel_q) done_d = 1'b1;
                else begin
                    tgt_d   = cmd_sel;
                    state_d = QUIESCE;
                    hold_d  = 1'b1;
`ifdef CLK_DIV_SEL_TIMEOUT_EN
                    cnt_d   = CW'(TIMEOUT_CYC - 1);
`endif
                end
            end
            QUIESCE: if (hold_ack) begin
                state_d = SWITCH;
                sel_d   = tgt_q;
                cnt_d   = CW'(SETTLE_CYC - 1);
            end
`ifdef CLK_DIV_SEL_TIMEOUT_EN
            else if (cnt_q == '0) begin
                state_d = IDLE;
                hold_d  = 1'b0;
                err_d   = 1'b1;
            end else cnt_d = cnt_q - CW'(1);
`endif
            SWITCH: if (cnt_q == '0) begin
                state_d = RELEASE;
                hold_d  = 1'b0;
            end else cnt_d = cnt_q - CW'(1);
            RELEASE: if (!hold_ack) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cmd_ready  = (state_q == IDLE) && !dft_en && !rst;
        accept     = cmd_valid && cmd_ready;
        busy       = state_q != IDLE;
        hold_req   = hold_q;
        divclk_sel = sel_q;
        done       = done_q;
`ifdef CLK_DIV_SEL_TIMEOUT_EN
        err        = err_q;
`else
        err        = 1'b0;
`endif
    end
endmodule
